// File: rtl/galaga_pkg.sv
// Shared definitions for the Galaga button conditioning slice: button
// indices, per-channel debounce state encoding and o_Move encodings.
package galaga_pkg;

   localparam int NUM_BTN  = 4;
   localparam int BTN_SS   = 0;
   localparam int BTN_L    = 1;
   localparam int BTN_R    = 2;
   localparam int BTN_FIRE = 3;

   typedef enum logic [1:0] {
      REL   = 2'b00,
      P_CHK = 2'b01,
      HELD  = 2'b10,
      R_CHK = 2'b11
   } btn_state_e;

   localparam logic [1:0] MV_NONE = 2'b00;
   localparam logic [1:0] MV_L    = 2'b01;
   localparam logic [1:0] MV_R    = 2'b10;

   // Exactly one direction held selects it; none or both held means no move.
   function automatic logic [1:0] move_enc(input logic left_lvl, input logic right_lvl);
      logic [1:0] mv;
      case ({right_lvl, left_lvl})
         2'b01:   mv = MV_L;
         2'b10:   mv = MV_R;
         default: mv = MV_NONE;
      endcase
      return mv;
   endfunction

endpackage

// File: rtl/galaga_btn_cond_if.sv
// Button bus between the board/test harness and the conditioning block:
// raw buttons in, debounced levels, press pulses and game-facing strobes out.
interface galaga_btn_cond_if;
   import galaga_pkg::*;

   logic [NUM_BTN-1:0] i_Btn;
   logic [NUM_BTN-1:0] o_BtnLevel;
   logic [NUM_BTN-1:0] o_BtnPulse;
   logic               o_fGameStartStop;
   logic [1:0]         o_Move;
   logic               o_fFire;

   modport master (
      output i_Btn,
      input  o_BtnLevel,
      input  o_BtnPulse,
      input  o_fGameStartStop,
      input  o_Move,
      input  o_fFire
   );

   modport slave (
      input  i_Btn,
      output o_BtnLevel,
      output o_BtnPulse,
      output o_fGameStartStop,
      output o_Move,
      output o_fFire
   );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, press/release qualification
// FSM with a shared stability counter, registered level and press pulse.
module btn_debounce
   import galaga_pkg::*;
#(
   parameter int DEB_CNT = 1_000_000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Btn,
   output logic o_Level,
   output logic o_Pulse,
   output logic o_Held
);

   localparam int             CW       = $clog2(DEB_CNT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

   logic          sync1_q;
   logic          sync2_q;
   btn_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_Btn;
         sync2_q <= sync1_q;
      end
   end

   // Qualify presses and releases; a level change is accepted only after it
   // has been stable for DEB_CNT cycles, otherwise the previous state resumes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         REL: begin
            cnt_d = '0;
            if (sync2_q) begin
               state_d = P_CHK;
            end else begin
               state_d = REL;
            end
         end
         P_CHK: begin
            if (!sync2_q) begin
               state_d = REL;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            cnt_d = '0;
            if (!sync2_q) begin
               state_d = R_CHK;
            end else begin
               state_d = HELD;
            end
         end
         R_CHK: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = REL;
            cnt_d   = '0;
         end
      endcase
      level_d = (state_d == HELD) || (state_d == R_CHK);
   end

   // State, counter and registered outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= REL;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign o_Level = level_q;
   assign o_Pulse = pulse_q;
   assign o_Held  = (state_q == HELD);

endmodule

// File: rtl/galaga_btn_cond.sv
// Galaga button conditioning top: four debounced channels, movement decode,
// start/stop strobe alias and fire output.
// Optional fire auto-repeat is built when GALAGA_FIRE_RPT_EN is defined.
module galaga_btn_cond
   import galaga_pkg::*;
#(
   parameter int DEB_CNT = 1_000_000,
   parameter int RPT_DLY = 30_000_000,
   parameter int RPT_PER = 10_000_000
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   galaga_btn_cond_if.slave   btn_if
);

   logic [NUM_BTN-1:0] level_s;
   logic [NUM_BTN-1:0] pulse_s;
   logic [NUM_BTN-1:0] held_s;
   logic [NUM_BTN-1:0] held_unused_s;
   logic               rpt_fire_s;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_debounce #(
         .DEB_CNT (DEB_CNT)
      ) u_deb (
         .i_Clk   (i_Clk),
         .i_Rst   (i_Rst),
         .i_Btn   (btn_if.i_Btn[gi]),
         .o_Level (level_s[gi]),
         .o_Pulse (pulse_s[gi]),
         .o_Held  (held_s[gi])
      );
   end

   // Only the fire channel's HELD flag feeds logic, and only with repeat built.
   assign held_unused_s = held_s;

`ifdef GALAGA_FIRE_RPT_EN
   localparam int            RPT_MAX  = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int            RW       = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_per_q, rpt_per_d;     // 0: initial delay, 1: periodic
   logic          rpt_pulse_q, rpt_pulse_d;

   // Count fire hold time in HELD; leaving HELD rearms the initial delay.
   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_per_d   = rpt_per_q;
      rpt_pulse_d = 1'b0;
      if (held_s[BTN_FIRE]) begin
         if (rpt_cnt_q == (rpt_per_q ? PER_LAST : DLY_LAST)) begin
            rpt_cnt_d   = '0;
            rpt_per_d   = 1'b1;
            rpt_pulse_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
         end
      end else begin
         rpt_cnt_d = '0;
         rpt_per_d = 1'b0;
      end
   end

   // Repeat counter, phase and pulse registers.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         rpt_cnt_q   <= '0;
         rpt_per_q   <= 1'b0;
         rpt_pulse_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_per_q   <= rpt_per_d;
         rpt_pulse_q <= rpt_pulse_d;
      end
   end

   assign rpt_fire_s = rpt_pulse_q;
`else
   localparam int RPT_UNUSED = RPT_DLY + RPT_PER;
   assign rpt_fire_s = 1'b0;
`endif

   assign btn_if.o_BtnLevel       = level_s;
   assign btn_if.o_BtnPulse       = pulse_s;
   assign btn_if.o_fGameStartStop = pulse_s[BTN_SS];
   assign btn_if.o_Move           = move_enc(level_s[BTN_L], level_s[BTN_R]);
   assign btn_if.o_fFire          = pulse_s[BTN_FIRE] | rpt_fire_s;

endmodule

// File: doc/galaga_btn_cond.md
Name: galaga_btn_cond

Overview:
- Input conditioning stage directly upstream of the Galaga FND game timer.
- Takes the four raw board push-buttons: start/stop, left, right and fire.
- Synchronises and debounces each button, then produces single-cycle press pulses and stable levels.
- o_fGameStartStop drives the timer's i_fGameStartStop; the movement and fire outputs feed the game logic.

Parameters:
- DEB_CNT, 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥2.
- RPT_DLY, 30_000_000: cycles a held fire button waits in HELD before the first auto-repeat pulse (300 ms).
- RPT_PER, 10_000_000: cycles between subsequent auto-repeat pulses (100 ms).

Ports:
- i_Clk  in  1  system clock, 100 MHz
- i_Rst  in  1  synchronous, active-high reset
- i_Btn  in  4  raw asynchronous buttons, active-high; [0]=start/stop, [1]=left, [2]=right, [3]=fire
- o_BtnLevel  out  4  debounced level per button
- o_BtnPulse  out  4  one-cycle press pulse per button
- o_fGameStartStop  out  1  equals o_BtnPulse[0]
- o_Move  out  2  01=left, 10=right, 00=none or both held
- o_fFire  out  1  fire pulse, includes auto-repeat when the optional feature is enabled

Behaviour:
- Reset: one clock is used, with synchronous active-high reset i_Rst. Every flop clears on the i_Clk edge where i_Rst=1:
  - synchroniser flops = 0
  - all channel FSMs = REL
  - all counters = 0
  - every output = 0
  - reset mid-debounce discards the in-progress count
- Synchroniser: two-flop synchroniser per bit. The FSMs see only the second-stage flop, s.
- Channel FSM (four independent instances). Counter width is $clog2(DEB_CNT).
  - REL: s=1 → P_CHK, cnt=0.
  - P_CHK:
    - s=0 → REL (glitch rejected, no pulse).
    - Otherwise cnt++.
    - At cnt==DEB_CNT-1 with s=1 → HELD.
  - HELD: s=0 → R_CHK, cnt=0.
  - R_CHK:
    - s=1 → HELD, with no new pulse.
    - Otherwise cnt++.
    - At cnt==DEB_CNT-1 with s=0 → REL.
- Level and pulse:
  - o_BtnLevel[i]=1 when the FSM is in HELD or R_CHK, else 0.
  - o_BtnPulse[i]=1 for exactly the first cycle after the P_CHK→HELD transition. It is registered.
- Latency: input rising before edge 1 and stable gives o_BtnPulse high in the cycle following edge DEB_CNT+3. Release latency to level=0 is also DEB_CNT+3.
- Pulse rate: at most one pulse per accepted press. Bounce during R_CHK returns to HELD silently.
- o_Move: derived combinationally from o_BtnLevel[2:1]. Both held gives 00.
- Fire without repeat: o_fFire = o_BtnPulse[3].
- Independence: channels never interact. Simultaneous presses on any mix of channels pulse in the same cycle.
- Button held through reset release: sync restarts from 0, so exactly one press pulse appears DEB_CNT+3 cycles after i_Rst falls.

Optional Feature:
- Macro: GALAGA_FIRE_RPT_EN.
- Defined:
  - A repeat counter runs while channel 3 is in HELD. Width is $clog2(max(RPT_DLY,RPT_PER)).
  - The counter clears on press acceptance and on entering R_CHK. A bounce back to HELD restarts the initial delay.
  - First extra pulse on o_fFire arrives RPT_DLY cycles after the press pulse, then every RPT_PER cycles while in HELD.
  - o_BtnPulse[3] never repeats.
- Undefined: no repeat counter is synthesised, and o_fFire = o_BtnPulse[3].

Decomposition:
- Package galaga_pkg holds:
  - button index constants BTN_SS=0, BTN_L=1, BTN_R=2, BTN_FIRE=3
  - FSM state encodings REL/P_CHK/HELD/R_CHK (2-bit)
  - o_Move encodings MV_NONE, MV_L, MV_R
- Sub-module btn_debounce: one channel containing synchroniser, FSM, counter, level and pulse. It is instantiated four times.
- The top level adds o_Move, fire auto-repeat and the o_fGameStartStop alias.

Test Plan (DEB_CNT=4, RPT_DLY=20, RPT_PER=8):
- Clean press: i_Btn[0] high at cycle 10 and held → o_BtnPulse[0]/o_fGameStartStop high only in cycle 17. o_BtnLevel[0] high from 17. Release at 40 → level low at 47, with no second pulse.
- Glitch reject: i_Btn[1] high for 3 cycles then low → o_BtnPulse[1] never asserts, o_BtnLevel[1] stays 0, o_Move=00.
- Release bounce: fire held and accepted, then drop for 2 cycles and restore → o_BtnLevel[3] stays 1 and no extra o_BtnPulse[3].
- Simultaneous inputs:
  - left+right rise in the same cycle → both pulses in the same cycle, o_Move=00.
  - drop right → o_Move=01 after 7 cycles.
- Reset: assert i_Rst in P_CHK mid-count → all outputs 0 next edge. With the button still held, deassert → exactly one pulse 7 cycles after i_Rst falls.
- Repeat (GALAGA_FIRE_RPT_EN): hold fire 60 cycles after its press pulse at cycle T → o_fFire at T, T+20, T+28, T+36, T+44, T+52, T+60. Without the macro → o_fFire only at T.
